// File: rtl/round_watchdog_if.sv
// Handshake bundle between the round controller and the game logic / watchdog.
// The slave modport is the controller's view; master is the environment's.
interface round_watchdog_if;
  logic       start_i;
  logic       kick_i;
  logic       abort_i;
  logic       wd_expire_i;
  logic       tick_o;
  logic       wd_enable_o;
  logic [3:0] sec_left_o;
  logic       timeout_o;
  logic [1:0] strikes_o;
  logic       game_over_o;
  logic [1:0] state_o;

  modport slave (
    input  start_i, kick_i, abort_i, wd_expire_i,
    output tick_o, wd_enable_o, sec_left_o, timeout_o, strikes_o, game_over_o, state_o
  );

  modport master (
    output start_i, kick_i, abort_i, wd_expire_i,
    input  tick_o, wd_enable_o, sec_left_o, timeout_o, strikes_o, game_over_o, state_o
  );
endinterface

// File: rtl/round_watchdog_ctrl.sv
// Quiz-round controller: arms an external 1000-tick watchdog, counts down seconds,
// records timeouts as strikes and ends the game after MAX_STRIKES of them.
module round_watchdog_ctrl #(
  parameter int unsigned CLK_PER_TICK  = 50000,
  parameter int unsigned ROUND_SECONDS = 10,
  parameter int unsigned MAX_STRIKES   = 3
) (
  input  logic            clk,
  input  logic            rst,
  round_watchdog_if.slave bus
);

  localparam int unsigned   PW           = (CLK_PER_TICK > 1) ? $clog2(CLK_PER_TICK) : 1;
  localparam logic [PW-1:0] PRESCALE_MAX = PW'(CLK_PER_TICK - 1);
  localparam logic [3:0]    ROUND_LOAD   = 4'(ROUND_SECONDS);
  localparam logic [1:0]    STRIKE_MAX   = 2'(MAX_STRIKES);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    EXPIRED = 2'd2,
    OVER    = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [3:0]    sec_left_q, sec_left_d;
  logic [1:0]    strikes_q, strikes_d;
  logic          tick_q, tick_d;
  logic          wd_enable_q, timeout_q, game_over_q;
  logic          stay_armed;

  // NOTE: every signal written here gets a default first, so no path leaves one unassigned (no latches).
  always_comb begin
    state_d    = state_q;
    sec_left_d = sec_left_q;
    strikes_d  = strikes_q;

    case (state_q)
      IDLE: begin
        if (bus.start_i) begin
          state_d    = ARMED;
          sec_left_d = ROUND_LOAD;
        end
      end
      ARMED: begin
        // abort beats kick, kick beats the watchdog
        if (bus.abort_i || bus.kick_i) begin
          state_d = IDLE;
        end else if (bus.wd_expire_i) begin
          if (sec_left_q > 4'd1) begin
            sec_left_d = sec_left_q - 4'd1;
          end else begin
            state_d    = EXPIRED;
            sec_left_d = 4'd0;
            strikes_d  = (strikes_q >= STRIKE_MAX) ? STRIKE_MAX : strikes_q + 2'd1;
          end
        end
      end
      EXPIRED: begin
        state_d = (strikes_q == STRIKE_MAX) ? OVER : IDLE;
      end
      OVER: begin
        if (bus.start_i) begin
          state_d    = ARMED;
          sec_left_d = ROUND_LOAD;
          strikes_d  = 2'd0;
        end
      end
      default: state_d = IDLE;
    endcase

    // Prescaler only runs across consecutive ARMED cycles; any entry into ARMED starts from 0.
    stay_armed = (state_q == ARMED) && (state_d == ARMED);
    presc_d    = '0;
    tick_d     = 1'b0;
    if (stay_armed) begin
      presc_d = (presc_q == PRESCALE_MAX) ? '0 : presc_q + 1'b1;
      tick_d  = (presc_q == PRESCALE_MAX);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      presc_q     <= '0;
      sec_left_q  <= 4'd0;
      strikes_q   <= 2'd0;
      tick_q      <= 1'b0;
      wd_enable_q <= 1'b0;
      timeout_q   <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      presc_q     <= presc_d;
      sec_left_q  <= sec_left_d;
      strikes_q   <= strikes_d;
      tick_q      <= tick_d;
      wd_enable_q <= (state_d == ARMED);
      timeout_q   <= (state_d == EXPIRED);
      game_over_q <= (state_d == OVER);
    end
  end

  assign bus.tick_o      = tick_q;
  assign bus.wd_enable_o = wd_enable_q;
  assign bus.sec_left_o  = sec_left_q;
  assign bus.timeout_o   = timeout_q;
  assign bus.strikes_o   = strikes_q;
  assign bus.game_over_o = game_over_q;
  assign bus.state_o     = state_q;

endmodule
